// File: rtl/conv_sched_pkg.sv
// Shared types and sizing for the conv/accumulate scheduler.
package conv_sched_pkg;

  localparam int DATA_WIDTH  = 15;
  localparam int MAX_NEURONS = 256;
  localparam int MAX_GROUPS  = 64;
  localparam int CONV_LAT    = 5;
  localparam int NW          = $clog2(MAX_NEURONS);
  localparam int GW          = $clog2(MAX_GROUPS);

  function automatic int res_width(input int dw);
    return 2 * (dw + 1);
  endfunction

  localparam int RW = res_width(DATA_WIDTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  typedef struct packed {
    logic          valid;
    logic          last;
    logic [NW-1:0] idx;
  } tag_t;

  localparam tag_t TAG_EMPTY = '{valid: 1'b0, last: 1'b0, idx: {NW{1'b0}}};

endpackage

// File: rtl/conv_sched_if.sv
// Datapath and result bus between the scheduler and the conv datapath/consumer.
interface conv_sched_if;
  import conv_sched_pkg::*;

  logic [NW+GW-1:0] w_addr;
  logic [GW-1:0]    spike_sel;
  logic             conv_en;
  logic             conv_acc_clear_and_go;
  logic             conv_acc_clear;
  logic [RW-1:0]    conv_out;
  logic             conv_valid;
  logic             res_valid;
  logic [RW-1:0]    res_data;
  logic [NW-1:0]    res_idx;

  modport master (
    output w_addr, spike_sel, conv_en, conv_acc_clear_and_go, conv_acc_clear,
    output res_valid, res_data, res_idx,
    input  conv_out, conv_valid
  );

  modport slave (
    input  w_addr, spike_sel, conv_en, conv_acc_clear_and_go, conv_acc_clear,
    input  res_valid, res_data, res_idx,
    output conv_out, conv_valid
  );

endinterface

// File: rtl/conv_sched_tagpipe.sv
// Request-tag delay line matching the datapath latency; the exiting tag
// says whether the datapath result belongs to the last group of a neuron.
module conv_sched_tagpipe
  import conv_sched_pkg::*;
#(
  parameter int DEPTH = CONV_LAT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic flush,
  input  tag_t tag_in,
  output tag_t tag_out,
  output logic any_valid
);

  tag_t stage_r [DEPTH];

  // Shift register: one stage per cycle, flush empties every stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) stage_r[i] <= TAG_EMPTY;
    end else if (flush) begin
      for (int i = 0; i < DEPTH; i++) stage_r[i] <= TAG_EMPTY;
    end else begin
      stage_r[0] <= tag_in;
      for (int i = 1; i < DEPTH; i++) stage_r[i] <= stage_r[i-1];
    end
  end

  // Any request still travelling through the datapath
  always_comb begin
    any_valid = 1'b0;
    for (int i = 0; i < DEPTH; i++) any_valid = any_valid | stage_r[i].valid;
  end

  assign tag_out = stage_r[DEPTH-1];

endmodule

// File: rtl/conv_sched.sv
// Sequencer for the 4-input SIMD conv/accumulate datapath.
// Optional performance counters are built when CONV_SCHED_PERF_EN is defined.
module conv_sched
  import conv_sched_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            abort,
  input  logic            hold,
  input  logic [NW:0]     cfg_neurons,
  input  logic [GW:0]     cfg_groups,
  output logic            busy,
  output logic            done,
  conv_sched_if.master    bus
`ifdef CONV_SCHED_PERF_EN
  ,
  output logic [31:0]     perf_busy_cycles,
  output logic [31:0]     perf_hold_cycles,
  output logic [15:0]     perf_drop_cnt
`endif
);

  state_t           state_r, state_s;
  logic [NW:0]      cfg_n_r;
  logic [GW:0]      cfg_g_r;
  logic [NW-1:0]    n_r;
  logic [GW-1:0]    g_r;
  logic [NW+GW-1:0] addr_r;

  logic start_ok_s, abort_s, in_issue_s, issue_s;
  logic g_last_s, n_last_s, cfg_zero_s, flush_s, pipe_any_s, capture_s;
  tag_t tag_in_s, pipe_out_s, cap_tag_r;

  logic             conv_en_r, clr_go_r, acc_clr_r;
  logic [NW+GW-1:0] w_addr_r;
  logic [GW-1:0]    spike_sel_r;
  logic             res_valid_r, busy_r, done_r;
  logic [RW-1:0]    res_data_r;
  logic [NW-1:0]    res_idx_r;

  // Qualified control events and the tag for the group issued this cycle
  always_comb begin
    start_ok_s     = (state_r == IDLE) && start;
    abort_s        = (state_r != IDLE) && abort;
    in_issue_s     = (state_r == ISSUE) && !abort_s;
    issue_s        = in_issue_s && !hold;
    g_last_s       = ({1'b0, g_r} == (cfg_g_r - {{GW{1'b0}}, 1'b1}));
    n_last_s       = ({1'b0, n_r} == (cfg_n_r - {{NW{1'b0}}, 1'b1}));
    cfg_zero_s     = (cfg_neurons == {(NW+1){1'b0}}) || (cfg_groups == {(GW+1){1'b0}});
    flush_s        = start_ok_s || abort_s;
    tag_in_s.valid = issue_s;
    tag_in_s.last  = g_last_s;
    tag_in_s.idx   = n_r;
    capture_s      = cap_tag_r.valid && cap_tag_r.last && bus.conv_valid && !abort_s;
  end

  // Next-state logic; abort overrides everything else
  always_comb begin
    state_s = state_r;
    if (abort_s) begin
      state_s = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) state_s = cfg_zero_s ? DONE : ISSUE;
          else       state_s = IDLE;
        end
        ISSUE: begin
          if (issue_s && g_last_s && n_last_s) state_s = DRAIN;
          else                                 state_s = ISSUE;
        end
        DRAIN: begin
          if (!pipe_any_s) state_s = DONE;
          else             state_s = DRAIN;
        end
        DONE:    state_s = IDLE;
        default: state_s = IDLE;
      endcase
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= IDLE;
    else        state_r <= state_s;
  end

  // Config capture and (neuron, group, address) walk; address increments instead of multiplying
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_n_r <= {(NW+1){1'b0}};
      cfg_g_r <= {(GW+1){1'b0}};
      n_r     <= {NW{1'b0}};
      g_r     <= {GW{1'b0}};
      addr_r  <= {(NW+GW){1'b0}};
    end else if (start_ok_s) begin
      cfg_n_r <= cfg_neurons;
      cfg_g_r <= cfg_groups;
      n_r     <= {NW{1'b0}};
      g_r     <= {GW{1'b0}};
      addr_r  <= {(NW+GW){1'b0}};
    end else if (issue_s) begin
      addr_r <= addr_r + (NW+GW)'(1'b1);
      if (g_last_s) begin
        g_r <= {GW{1'b0}};
        n_r <= n_r + NW'(1'b1);
      end else begin
        g_r <= g_r + GW'(1'b1);
      end
    end else begin
      addr_r <= addr_r;
    end
  end

  conv_sched_tagpipe #(.DEPTH(CONV_LAT)) u_tagpipe (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush_s),
    .tag_in    (tag_in_s),
    .tag_out   (pipe_out_s),
    .any_valid (pipe_any_s)
  );

  // Registered outputs; the exiting tag is held one more cycle to line up with conv_valid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      conv_en_r   <= 1'b0;
      clr_go_r    <= 1'b0;
      acc_clr_r   <= 1'b0;
      w_addr_r    <= {(NW+GW){1'b0}};
      spike_sel_r <= {GW{1'b0}};
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      cap_tag_r   <= TAG_EMPTY;
      res_valid_r <= 1'b0;
      res_data_r  <= {RW{1'b0}};
      res_idx_r   <= {NW{1'b0}};
    end else begin
      conv_en_r   <= issue_s;
      clr_go_r    <= issue_s && (g_r == {GW{1'b0}});
      acc_clr_r   <= flush_s;
      w_addr_r    <= in_issue_s ? addr_r : {(NW+GW){1'b0}};
      spike_sel_r <= in_issue_s ? g_r : {GW{1'b0}};
      busy_r      <= (state_s != IDLE);
      done_r      <= (state_r == DONE) && !abort_s;
      cap_tag_r   <= flush_s ? TAG_EMPTY : pipe_out_s;
      res_valid_r <= capture_s;
      if (capture_s) begin
        res_data_r <= bus.conv_out;
        res_idx_r  <= cap_tag_r.idx;
      end else begin
        res_data_r <= res_data_r;
      end
    end
  end

`ifdef CONV_SCHED_PERF_EN
  logic        drop_s;
  logic [31:0] busy_cnt_r, hold_cnt_r;
  logic [15:0] drop_cnt_r;

  assign drop_s = cap_tag_r.valid && !bus.conv_valid && !abort_s;

  // Saturating run statistics, cleared when a run is accepted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_cnt_r <= 32'd0;
      hold_cnt_r <= 32'd0;
      drop_cnt_r <= 16'd0;
    end else if (start_ok_s) begin
      busy_cnt_r <= 32'd0;
      hold_cnt_r <= 32'd0;
      drop_cnt_r <= 16'd0;
    end else begin
      if (busy_r && (busy_cnt_r != 32'hFFFF_FFFF)) busy_cnt_r <= busy_cnt_r + 32'd1;
      if (in_issue_s && hold && (hold_cnt_r != 32'hFFFF_FFFF)) hold_cnt_r <= hold_cnt_r + 32'd1;
      if (drop_s && (drop_cnt_r != 16'hFFFF)) drop_cnt_r <= drop_cnt_r + 16'd1;
    end
  end

  assign perf_busy_cycles = busy_cnt_r;
  assign perf_hold_cycles = hold_cnt_r;
  assign perf_drop_cnt    = drop_cnt_r;
`endif

  assign bus.conv_en               = conv_en_r;
  assign bus.conv_acc_clear_and_go = clr_go_r;
  assign bus.conv_acc_clear        = acc_clr_r;
  assign bus.w_addr                = w_addr_r;
  assign bus.spike_sel             = spike_sel_r;
  assign bus.res_valid             = res_valid_r;
  assign bus.res_data              = res_data_r;
  assign bus.res_idx               = res_idx_r;
  assign busy                      = busy_r;
  assign done                      = done_r;

endmodule

// File: tb/tb_conv_sched.sv
// Directed bench for conv_sched with a behavioural accumulating datapath.
module tb_conv_sched;
  import conv_sched_pkg::*;

  logic          clk = 1'b0;
  logic          rst_n, start, abort, hold, kill_valid;
  logic [NW:0]   cfg_neurons;
  logic [GW:0]   cfg_groups;
  logic          busy, done;
  int            cyc = 0;
  int            n_chk = 0;
  int            n_fail = 0;

  conv_sched_if bus ();

`ifdef CONV_SCHED_PERF_EN
  logic [31:0] perf_busy_cycles, perf_hold_cycles;
  logic [15:0] perf_drop_cnt;
`endif

  conv_sched dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .abort       (abort),
    .hold        (hold),
    .cfg_neurons (cfg_neurons),
    .cfg_groups  (cfg_groups),
    .busy        (busy),
    .done        (done),
    .bus         (bus)
`ifdef CONV_SCHED_PERF_EN
    ,
    .perf_busy_cycles (perf_busy_cycles),
    .perf_hold_cycles (perf_hold_cycles),
    .perf_drop_cnt    (perf_drop_cnt)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [RW-1:0] val(input int a);
    return 32'(a) * 32'd37 + 32'd5;
  endfunction

  // Datapath model: accumulate per group, result appears CONV_LAT cycles after conv_en
  logic          vp [CONV_LAT];
  logic [RW-1:0] dp [CONV_LAT];
  logic [RW-1:0] acc_m;
  always @(posedge clk or negedge rst_n) begin
    logic [RW-1:0] nv;
    if (!rst_n) begin
      acc_m <= '0;
      for (int i = 0; i < CONV_LAT; i++) begin vp[i] <= 1'b0; dp[i] <= '0; end
    end else begin
      nv = bus.conv_acc_clear_and_go ? val(int'(bus.w_addr)) : acc_m + val(int'(bus.w_addr));
      if (bus.conv_en) acc_m <= nv;
      vp[0] <= bus.conv_en;
      dp[0] <= nv;
      for (int i = 1; i < CONV_LAT; i++) begin vp[i] <= vp[i-1]; dp[i] <= dp[i-1]; end
    end
  end
  assign bus.conv_valid = vp[CONV_LAT-1] && !kill_valid;
  assign bus.conv_out   = dp[CONV_LAT-1];

  typedef struct {
    int n; int g; int hold_after; int hold_len; bit kill;
    int exp_issues; int exp_res; int exp_done;
  } vec_t;
  typedef struct { int cyc; logic [NW+GW-1:0] addr; logic [GW-1:0] sel; logic go; } iss_t;
  typedef struct { int cyc; logic [NW-1:0] idx; logic [RW-1:0] data; } res_t;

  vec_t             vecs [9];
  iss_t             iss_q [$];
  res_t             res_q [$];
  logic             wen_a [512];
  logic [NW+GW-1:0] wad_a [512];
  int               done_rel, busy_cnt;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [RW-1:0] exp_sum(input int k, input int g);
    logic [RW-1:0] s;
    s = '0;
    for (int j = 0; j < g; j++) s = s + val(k * g + j);
    return s;
  endfunction

  // Cycle (relative to the start cycle) at which issue k is visible
  function automatic int iss_exp_cyc(input vec_t v, input int k);
    return 2 + k + (((v.hold_len > 0) && (k >= v.hold_after)) ? v.hold_len : 0);
  endfunction

  task automatic check_idle_outputs(input string name);
    check(name, {bus.conv_en, bus.conv_acc_clear_and_go, bus.conv_acc_clear, bus.res_valid,
                 busy, done, bus.w_addr, bus.spike_sel, bus.res_idx}, 64'd0);
    check({name, "_data"}, bus.res_data, 64'd0);
  endtask

  task automatic run(input vec_t v, input int row);
    int  s, rel, hold_left, last;
    bit  fin;
    iss_q.delete();
    res_q.delete();
    done_rel = -1; busy_cnt = 0; hold_left = 0; fin = 1'b0;
    for (int i = 0; i < 512; i++) begin wen_a[i] = 1'b0; wad_a[i] = '0; end
    @(negedge clk);
    cfg_neurons = (NW+1)'(v.n);
    cfg_groups  = (GW+1)'(v.g);
    kill_valid  = v.kill;
    start       = 1'b1;
    s           = cyc;
    for (int t = 0; t < 400 && !fin; t++) begin
      @(negedge clk);
      start = 1'b0;
      rel = cyc - s;
      wen_a[rel] = bus.conv_en;
      wad_a[rel] = bus.w_addr;
      if (busy) busy_cnt++;
      if (bus.conv_en) iss_q.push_back('{rel, bus.w_addr, bus.spike_sel, bus.conv_acc_clear_and_go});
      if (bus.res_valid) res_q.push_back('{rel, bus.res_idx, bus.res_data});
      if (done) begin done_rel = rel; fin = 1'b1; end
      if (v.hold_len > 0 && bus.conv_en && iss_q.size() == v.hold_after) hold_left = v.hold_len;
      if (hold_left > 0) begin hold = 1'b1; hold_left--; end else hold = 1'b0;
    end
    hold = 1'b0;
    check($sformatf("r%0d_done_lat", row), done_rel, v.exp_done);
    check($sformatf("r%0d_busy_cycles", row), busy_cnt, v.exp_done - 1);
    check($sformatf("r%0d_issue_cnt", row), iss_q.size(), v.exp_issues);
    foreach (iss_q[k]) begin
      check($sformatf("r%0d_issue%0d_addr_sel_go", row, k),
            {iss_q[k].addr, iss_q[k].sel, iss_q[k].go},
            {(NW+GW)'(k), GW'(k % v.g), 1'((k % v.g) == 0)});
      check($sformatf("r%0d_issue%0d_cyc", row, k), iss_q[k].cyc, iss_exp_cyc(v, k));
    end
    check($sformatf("r%0d_res_cnt", row), res_q.size(), v.exp_res);
    foreach (res_q[k]) begin
      last = k * v.g + v.g - 1;
      check($sformatf("r%0d_res%0d_idx", row, k), res_q[k].idx, k);
      check($sformatf("r%0d_res%0d_data", row, k), res_q[k].data, exp_sum(k, v.g));
      check($sformatf("r%0d_res%0d_lat", row, k), res_q[k].cyc, iss_exp_cyc(v, last) + CONV_LAT + 1);
    end
    for (int j = 1; j <= v.hold_len; j++) begin
      rel = iss_exp_cyc(v, v.hold_after - 1) + j;
      check($sformatf("r%0d_hold%0d", row, j), {wen_a[rel], wad_a[rel]}, {1'b0, (NW+GW)'(v.hold_after)});
    end
`ifdef CONV_SCHED_PERF_EN
    check($sformatf("r%0d_perf_busy", row), perf_busy_cycles, v.exp_done - 1);
    check($sformatf("r%0d_perf_hold", row), perf_hold_cycles, v.hold_len);
    check($sformatf("r%0d_perf_drop", row), perf_drop_cnt, v.kill ? v.exp_issues : 0);
`endif
    kill_valid = 1'b0;
  endtask

  initial begin
    int cnt, n_res, n_done, n_en;
    bit hit;
    //        n    g  hold_after hold_len kill issues res done
    vecs[0] = '{1,   1,  0, 0, 1'b0,   1,   1,   9};
    vecs[1] = '{3,   4,  0, 0, 1'b0,  12,   3,  20};
    vecs[2] = '{3,   4,  5, 3, 1'b0,  12,   3,  23};
    vecs[3] = '{1,   0,  0, 0, 1'b0,   0,   0,   2};
    vecs[4] = '{0,   4,  0, 0, 1'b0,   0,   0,   2};
    vecs[5] = '{2,   1,  0, 0, 1'b0,   2,   2,  10};
    vecs[6] = '{1,  64,  0, 0, 1'b0,  64,   1,  72};
    vecs[7] = '{256, 1,  0, 0, 1'b0, 256, 256, 264};
    vecs[8] = '{1,   1,  0, 0, 1'b1,   1,   0,   9};

    rst_n = 1'b0; start = 1'b0; abort = 1'b0; hold = 1'b0; kill_valid = 1'b0;
    cfg_neurons = '0; cfg_groups = '0;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset_state");
    rst_n = 1'b1;

    for (int r = 0; r < 9; r++) run(vecs[r], r);

    // Abort at the 7th issue, with a coincident start that must be ignored
    @(negedge clk);
    cfg_neurons = 9'd3; cfg_groups = 7'd4; start = 1'b1;
    cnt = 0; hit = 1'b0;
    for (int t = 0; t < 40 && !hit; t++) begin
      @(negedge clk);
      start = 1'b0;
      if (bus.conv_en) cnt++;
      if (cnt == 7) hit = 1'b1;
    end
    check("abort_reach_7th_issue", hit, 1'b1);
    abort = 1'b1; start = 1'b1;
    @(negedge clk);
    abort = 1'b0; start = 1'b0;
    check("abort_busy", busy, 1'b0);
    check("abort_acc_clear", bus.conv_acc_clear, 1'b1);
    check("abort_conv_en", bus.conv_en, 1'b0);
    n_res = 0; n_done = 0; n_en = 0;
    repeat (30) begin
      @(negedge clk);
      if (bus.res_valid) n_res++;
      if (done) n_done++;
      if (bus.conv_en) n_en++;
    end
    check("abort_no_res", n_res, 0);
    check("abort_no_done", n_done, 0);
    check("abort_no_issue", n_en, 0);
    run(vecs[1], 10);

    // Asynchronous reset in the middle of ISSUE
    @(negedge clk);
    cfg_neurons = 9'd3; cfg_groups = 7'd4; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_pre_conv_en", bus.conv_en, 1'b1);
    rst_n = 1'b0;
    #1;
    check_idle_outputs("rst_mid_issue");
    @(negedge clk);
    rst_n = 1'b1;
    run(vecs[0], 11);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
